// File: rtl/engine_param_rx_pkg.sv
// Graphics engine common definitions shared by the command broadcast endpoints.
package engine_param_rx_pkg;

  // Width of the shared command broadcast data bus
  localparam int unsigned BCAST_W = 8;

  // Engine indices on the broadcast bus; 2..4 are reserved for future engines
  localparam int unsigned TEST_PAT  = 0;
  localparam int unsigned FILL_RECT = 1;

  // Receiver states
  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } rx_state_e;

  // Parameter packet length in bytes for each engine
  function automatic int unsigned engine_num_bytes(input int unsigned eng);
    case (eng)
      TEST_PAT:  return 1;  // pattern select
      FILL_RECT: return 9;  // x0,y0,x1,y1 (16 bit each) + color (8 bit)
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/engine_param_rx_param_byte_reg.sv
// Parameter word storage: NUM_BYTES bytes, one indexed byte write per cycle.
module param_byte_reg
  import engine_param_rx_pkg::*;
#(
  parameter int unsigned NUM_BYTES = 9,
  parameter int unsigned IDX_W     = 4
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         wr_en,
  input  logic [IDX_W-1:0]             wr_idx,
  input  logic [BCAST_W-1:0]           wr_data,
  output logic [NUM_BYTES*BCAST_W-1:0] data
);

  logic [NUM_BYTES-1:0][BCAST_W-1:0] mem;

  // Byte-indexed write; contents persist until overwritten or reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem <= '0;
    end else if (wr_en) begin
      mem[wr_idx] <= wr_data;
    end
  end

  assign data = mem;

endmodule

// File: rtl/engine_param_rx.sv
// Engine-side receiver for the command broadcast bus: qualifies broadcast bytes
// with this engine's rts, assembles NUM_BYTES of them into one parameter word and
// holds it for the engine core under a valid/ack handshake.
// Optional feature: define PARAM_RX_TIMEOUT_EN to drop partial packets after
// TIMEOUT_CYCLES idle cycles (pulsing timeout_err); otherwise COLLECT waits forever.
module engine_param_rx
  import engine_param_rx_pkg::*;
#(
  parameter int unsigned NUM_BYTES      = engine_num_bytes(FILL_RECT),
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [BCAST_W-1:0]             bcast_in_data,
  input  logic                           cmd_in_rts,
  output logic                           cmd_out_rtr,
  input  logic                           flush,
  output logic [NUM_BYTES*BCAST_W-1:0]   param_data,
  output logic                           param_valid,
  input  logic                           param_ack,
  output logic [$clog2(NUM_BYTES+1)-1:0] byte_cnt,
  output logic                           timeout_err
);

  localparam int unsigned CNT_W = $clog2(NUM_BYTES + 1);
  localparam int unsigned IDX_W = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;

  // Elaboration guard on the legal parameter ranges
  if (NUM_BYTES < 1 || NUM_BYTES > 32 || TIMEOUT_CYCLES < 2) begin : g_bad_param
    $error("engine_param_rx: parameter out of legal range");
  end

  rx_state_e        state_q;
  rx_state_e        state_d;
  logic             xfc;
  logic             last_byte;
  logic             wr_en;
  logic             timeout;
  logic             rtr_d;
  logic             valid_d;
  logic [CNT_W-1:0] cnt_d;

  // rtr is a flop, so the transfer qualifier never loops back through cmd_in_rts
  assign xfc       = cmd_in_rts && cmd_out_rtr;
  assign last_byte = (byte_cnt == CNT_W'(NUM_BYTES - 1));
  assign wr_en     = xfc && !flush;

`ifdef PARAM_RX_TIMEOUT_EN
  localparam int unsigned GAP_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [GAP_W-1:0] gap_q;

  // Idle-gap counter: runs only in COLLECT between transfers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gap_q <= '0;
    end else if ((state_q != COLLECT) || xfc || flush) begin
      gap_q <= '0;
    end else begin
      gap_q <= gap_q + GAP_W'(1);
    end
  end

  assign timeout = (state_q == COLLECT) && !xfc && !flush &&
                   (gap_q == GAP_W'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif

  // State register and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cmd_out_rtr <= 1'b1;
      param_valid <= 1'b0;
      byte_cnt    <= '0;
      timeout_err <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_out_rtr <= rtr_d;
      param_valid <= valid_d;
      byte_cnt    <= cnt_d;
      timeout_err <= timeout;
    end
  end

  // Next-state logic; flush overrides transfers and acks
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE, COLLECT: begin
        if (xfc) begin
          state_d = last_byte ? HOLD : COLLECT;
        end else if (timeout) begin
          state_d = IDLE;
        end
      end
      HOLD: begin
        if (param_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (flush) begin
      state_d = IDLE;
    end
  end

  // Next values of the registered outputs, derived from the next state
  always_comb begin
    rtr_d   = (state_d != HOLD);
    valid_d = (state_d == HOLD);
    cnt_d   = byte_cnt;
    if (state_d == IDLE) begin
      cnt_d = '0;
    end else if (xfc) begin
      cnt_d = byte_cnt + CNT_W'(1);
    end
  end

  param_byte_reg #(
    .NUM_BYTES (NUM_BYTES),
    .IDX_W     (IDX_W)
  ) u_byte_reg (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_idx  (IDX_W'(byte_cnt)),
    .wr_data (bcast_in_data),
    .data    (param_data)
  );

endmodule

// File: tb/tb_engine_param_rx.sv
// Directed bench for engine_param_rx with a packet-level reference model.
module tb_engine_param_rx;
  import engine_param_rx_pkg::*;

  localparam int unsigned NB = 9;
  localparam int unsigned TO = 16;
  localparam int unsigned DW = NB * 8;
`ifdef PARAM_RX_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic                         clk = 1'b0;
  logic                         rst = 1'b1;
  logic [7:0]                   bcast_in_data = '0;
  logic                         cmd_in_rts = 1'b0;
  logic                         cmd_out_rtr;
  logic                         flush = 1'b0;
  logic [DW-1:0]                param_data;
  logic                         param_valid;
  logic                         param_ack = 1'b0;
  logic [$clog2(NB+1)-1:0]      byte_cnt;
  logic                         timeout_err;

  int n_vec = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  engine_param_rx #(.NUM_BYTES(NB), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .bcast_in_data (bcast_in_data),
    .cmd_in_rts    (cmd_in_rts),
    .cmd_out_rtr   (cmd_out_rtr),
    .flush         (flush),
    .param_data    (param_data),
    .param_valid   (param_valid),
    .param_ack     (param_ack),
    .byte_cnt      (byte_cnt),
    .timeout_err   (timeout_err)
  );

  always #5 clk = ~clk;

  // Reference model: bytes of the open packet, held flag, stored word
  logic [7:0]    m_buf[$];
  logic [DW-1:0] m_data = '0;
  bit            m_hold = 1'b0;
  int            m_gap = 0;
  bit            m_terr = 1'b0;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_buf.delete();
        m_hold = 1'b0;
        m_data = '0;
        m_gap  = 0;
        m_terr = 1'b0;
      end else begin
        m_terr = 1'b0;
        if (flush) begin
          m_buf.delete();
          m_hold = 1'b0;
          m_gap  = 0;
        end else if (m_hold) begin
          if (param_ack) m_hold = 1'b0;
        end else if (cmd_in_rts) begin
          m_data[8*m_buf.size() +: 8] = bcast_in_data;
          m_buf.push_back(bcast_in_data);
          m_gap = 0;
          if (m_buf.size() == NB) begin
            m_buf.delete();
            m_hold = 1'b1;
          end
        end else if (m_buf.size() != 0) begin
          m_gap++;
          if (TO_EN && m_gap == TO) begin
            m_buf.delete();
            m_gap  = 0;
            m_terr = 1'b1;
          end
        end
      end
    end
  end

  task automatic cmp(input string nm, input logic [DW-1:0] got, input logic [DW-1:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Per-cycle compare of every output against the model
  initial begin
    forever begin
      @(negedge clk);
      if (!rst && chk_en) begin
        cmp("rtr", DW'(cmd_out_rtr), DW'(!m_hold));
        cmp("valid", DW'(param_valid), DW'(m_hold));
        cmp("byte_cnt", DW'(byte_cnt), m_hold ? DW'(NB) : DW'(m_buf.size()));
        cmp("data", param_data, m_data);
        cmp("timeout_err", DW'(timeout_err), DW'(m_terr));
      end
    end
  end

  task automatic drive_byte(input logic [7:0] b);
    cmd_in_rts    = 1'b1;
    bcast_in_data = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    cmd_in_rts = 1'b0;
    for (int i = 0; i < n; i++) begin
      bcast_in_data = 8'($urandom);
      @(negedge clk);
    end
  endtask

  task automatic send_seq(input logic [7:0] base, input int n);
    for (int i = 0; i < n; i++) drive_byte(base + 8'(i));
    cmd_in_rts = 1'b0;
  endtask

  task automatic do_ack();
    int w = 0;
    cmd_in_rts = 1'b0;
    while (!param_valid && w < 20) begin
      @(negedge clk);
      w++;
    end
    cmp("ack_wait_valid", DW'(param_valid), DW'(1));
    param_ack = 1'b1;
    @(negedge clk);
    param_ack = 1'b0;
    cmp("post_ack_valid", DW'(param_valid), DW'(0));
    cmp("post_ack_rtr", DW'(cmd_out_rtr), DW'(1));
  endtask

  initial begin
    logic [7:0] pkt1 [NB];
    int pulses;
    pkt1 = '{8'h10, 8'h00, 8'h20, 8'h00, 8'h30, 8'h00, 8'h40, 8'h00, 8'hAB};

    // Reset state
    repeat (2) @(negedge clk);
    cmp("rst_rtr", DW'(cmd_out_rtr), DW'(1));
    cmp("rst_valid", DW'(param_valid), DW'(0));
    cmp("rst_cnt", DW'(byte_cnt), DW'(0));
    rst = 1'b0;
    chk_en = 1'b1;
    idle(5);
    cmp("idle_rtr", DW'(cmd_out_rtr), DW'(1));

    // Full packet, rts continuously high
    for (int i = 0; i < NB; i++) drive_byte(pkt1[i]);
    cmp("pkt1_data", param_data, 72'hAB_0040_0030_0020_0010);
    cmp("pkt1_valid", DW'(param_valid), DW'(1));
    cmp("pkt1_rtr", DW'(cmd_out_rtr), DW'(0));

    // HOLD protection: rts high with 0xFF for 10 cycles, no ack
    cmd_in_rts    = 1'b1;
    bcast_in_data = 8'hFF;
    repeat (10) @(negedge clk);
    cmp("hold_data", param_data, 72'hAB_0040_0030_0020_0010);
    cmp("hold_cnt", DW'(byte_cnt), DW'(9));
    do_ack();

    // Gapped rts with garbage in between, then back-to-back packet
    for (int i = 0; i < NB; i++) begin
      drive_byte(8'hA1 + 8'(i));
      idle(1);
    end
    cmp("pkt2_data", param_data, 72'hA9A8A7A6A5A4A3A2A1);
    do_ack();
    send_seq(8'h01, NB);
    cmp("pkt3_data", param_data, 72'h090807060504030201);
    do_ack();

    // Stray ack in IDLE and during COLLECT is ignored
    param_ack = 1'b1;
    idle(2);
    drive_byte(8'h55);
    param_ack = 1'b0;
    cmp("stray_ack_cnt", DW'(byte_cnt), DW'(1));
    flush = 1'b1;
    idle(1);
    flush = 1'b0;

    // Flush together with a transfer after 4 bytes
    send_seq(8'hC1, 4);
    cmd_in_rts    = 1'b1;
    bcast_in_data = 8'hEE;
    flush         = 1'b1;
    @(negedge clk);
    flush      = 1'b0;
    cmd_in_rts = 1'b0;
    cmp("flush_cnt", DW'(byte_cnt), DW'(0));
    send_seq(8'hD1, NB);
    cmp("pkt4_data", param_data, 72'hD9D8D7D6D5D4D3D2D1);

    // Flush while holding: valid drops, data kept
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    cmp("hold_flush_valid", DW'(param_valid), DW'(0));
    cmp("hold_flush_data", param_data, 72'hD9D8D7D6D5D4D3D2D1);

    // Gap behaviour
`ifdef PARAM_RX_TIMEOUT_EN
    send_seq(8'h71, 3);
    pulses = 0;
    for (int i = 0; i < TO + 3; i++) begin
      @(negedge clk);
      if (timeout_err) pulses++;
    end
    cmp("timeout_pulses", DW'(pulses), DW'(1));
    cmp("timeout_cnt", DW'(byte_cnt), DW'(0));
    send_seq(8'hE1, 3);
    idle(TO - 1);
`else
    pulses = 0;
    send_seq(8'hE1, 3);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (timeout_err) pulses++;
    end
    cmp("no_timeout_pulses", DW'(pulses), DW'(0));
`endif
    send_seq(8'hE4, 6);
    cmp("gap_pkt_valid", DW'(param_valid), DW'(1));
    cmp("gap_pkt_data", param_data, 72'hE9E8E7E6E5E4E3E2E1);
    do_ack();

    // Asynchronous reset mid-packet
    send_seq(8'h31, 4);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    cmp("arst_rtr", DW'(cmd_out_rtr), DW'(1));
    cmp("arst_valid", DW'(param_valid), DW'(0));
    cmp("arst_cnt", DW'(byte_cnt), DW'(0));
    cmp("arst_data", param_data, DW'(0));
    @(negedge clk);
    rst = 1'b0;
    send_seq(8'h91, NB);
    cmp("post_rst_data", param_data, 72'h999897969594939291);
    do_ack();
    idle(3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
